// File: rtl/regfile_rob_rename.sv
// Architectural register file with per-register rename state (busy + ROB tag); reads are 1-cycle
// registered with same-cycle commit bypass and flush visibility; no backpressure, every request is answered.
module regfile_rob_rename #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int IDX_W = 5,
    parameter int TAG_W = 5,
    parameter int NREAD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD-1:0]        rdEnable,
    input  logic [NREAD*IDX_W-1:0]  rdIndex,
    output logic [NREAD-1:0]        rdValid,
    output logic [NREAD-1:0]        rdBusy,
    output logic [NREAD*TAG_W-1:0]  rdTag,
    output logic [NREAD*XLEN-1:0]   rdData,
    input  logic                    renameEnable,
    input  logic [IDX_W-1:0]        renameIndex,
    input  logic [TAG_W-1:0]        renameTag,
    input  logic                    commitEnable,
    input  logic [IDX_W-1:0]        commitIndex,
    input  logic [TAG_W-1:0]        commitTag,
    input  logic [XLEN-1:0]         commitData,
    input  logic                    flush
);

    logic [XLEN-1:0]  value_q [NREG];
    logic [XLEN-1:0]  value_d [NREG];
    logic [TAG_W-1:0] tag_q   [NREG];
    logic [TAG_W-1:0] tag_d   [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    logic [NREAD-1:0]       rd_valid_q, rd_valid_d;
    logic [NREAD-1:0]       rd_busy_q,  rd_busy_d;
    logic [NREAD*TAG_W-1:0] rd_tag_q,   rd_tag_d;
    logic [NREAD*XLEN-1:0]  rd_data_q,  rd_data_d;

    // Entry 0 is never written, so it keeps its reset value of zero.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if (commitEnable && commitIndex == IDX_W'(i)) begin
                value_d[i] = commitData;
                if (busy_q[i] && tag_q[i] == commitTag) begin
                    busy_d[i] = 1'b0;
                end
            end
            // A rename issued after the committing one keeps ownership; flush drops everything.
            if (flush) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end else if (renameEnable && renameIndex == IDX_W'(i)) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = renameTag;
            end
        end
    end

    logic [IDX_W-1:0] ri;
    logic             cm_hit;
    logic             bsy;
    logic [XLEN-1:0]  dv;
    logic [TAG_W-1:0] tv;

    // Reads see the old mapping for a same-cycle rename, but the commit value and flush are bypassed.
    always_comb begin
        rd_valid_d = rdEnable;
        rd_busy_d  = '0;
        rd_tag_d   = '0;
        rd_data_d  = '0;
        ri         = '0;
        cm_hit     = 1'b0;
        bsy        = 1'b0;
        dv         = '0;
        tv         = '0;
        for (int p = 0; p < NREAD; p++) begin
            ri     = rdIndex[p*IDX_W +: IDX_W];
            cm_hit = commitEnable && (commitIndex == ri);
            bsy    = busy_q[ri] && !flush && !(cm_hit && tag_q[ri] == commitTag);
            dv     = cm_hit ? commitData : value_q[ri];
            tv     = tag_q[ri];
            if (rdEnable[p] && ri != '0) begin
                rd_busy_d[p] = bsy;
                if (bsy) begin
                    rd_tag_d[p*TAG_W +: TAG_W] = tv;
                end else begin
                    rd_data_d[p*XLEN +: XLEN] = dv;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q    <= '{default: '0};
            tag_q      <= '{default: '0};
            busy_q     <= '0;
            rd_valid_q <= '0;
            rd_busy_q  <= '0;
            rd_tag_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            value_q    <= value_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_busy_q  <= rd_busy_d;
            rd_tag_q   <= rd_tag_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rdValid = rd_valid_q;
    assign rdBusy  = rd_busy_q;
    assign rdTag   = rd_tag_q;
    assign rdData  = rd_data_q;

endmodule

// File: tb/tb_regfile_rob_rename.sv
// Directed table-driven bench for regfile_rob_rename: each record is one cycle of inputs plus the
// read response expected on the following edge.
module tb_regfile_rob_rename;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rdEnable;
    logic [9:0]  rdIndex;
    logic [1:0]  rdValid;
    logic [1:0]  rdBusy;
    logic [9:0]  rdTag;
    logic [63:0] rdData;
    logic        renameEnable;
    logic [4:0]  renameIndex;
    logic [4:0]  renameTag;
    logic        commitEnable;
    logic [4:0]  commitIndex;
    logic [4:0]  commitTag;
    logic [31:0] commitData;
    logic        flush;

    always #5 clk = ~clk;

    regfile_rob_rename #(.XLEN(32), .NREG(32), .IDX_W(5), .TAG_W(5), .NREAD(2)) dut (
        .clk(clk), .rst(rst),
        .rdEnable(rdEnable), .rdIndex(rdIndex),
        .rdValid(rdValid), .rdBusy(rdBusy), .rdTag(rdTag), .rdData(rdData),
        .renameEnable(renameEnable), .renameIndex(renameIndex), .renameTag(renameTag),
        .commitEnable(commitEnable), .commitIndex(commitIndex), .commitTag(commitTag),
        .commitData(commitData), .flush(flush)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  re;
        logic [4:0]  ri0, ri1;
        logic        rn;
        logic [4:0]  rni, rnt;
        logic        cm;
        logic [4:0]  ci, ct;
        logic [31:0] cd;
        logic        fl;
        logic [1:0]  ev, eb;
        logic [4:0]  et0, et1;
        logic [31:0] ed0, ed1;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[17];

    function automatic vec_t mk(logic r, logic [1:0] re, logic [4:0] ri0, logic [4:0] ri1,
                                logic rn, logic [4:0] rni, logic [4:0] rnt,
                                logic cm, logic [4:0] ci, logic [4:0] ct, logic [31:0] cd,
                                logic fl, logic [1:0] ev, logic [1:0] eb,
                                logic [4:0] et0, logic [4:0] et1,
                                logic [31:0] ed0, logic [31:0] ed1);
        vec_t v;
        v.rst = r;  v.re = re;  v.ri0 = ri0; v.ri1 = ri1;
        v.rn = rn;  v.rni = rni; v.rnt = rnt;
        v.cm = cm;  v.ci = ci;  v.ct = ct;  v.cd = cd;  v.fl = fl;
        v.ev = ev;  v.eb = eb;  v.et0 = et0; v.et1 = et1; v.ed0 = ed0; v.ed1 = ed1;
        return v;
    endfunction

    task automatic check(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        @(negedge clk);
        rst          = v.rst;
        rdEnable     = v.re;
        rdIndex      = {v.ri1, v.ri0};
        renameEnable = v.rn;
        renameIndex  = v.rni;
        renameTag    = v.rnt;
        commitEnable = v.cm;
        commitIndex  = v.ci;
        commitTag    = v.ct;
        commitData   = v.cd;
        flush        = v.fl;
        @(posedge clk);
        #1;
        check("rdValid", id, 64'(rdValid), 64'(v.ev));
        check("rdBusy",  id, 64'(rdBusy),  64'(v.eb));
        check("rdTag",   id, 64'(rdTag),   64'({v.et1, v.et0}));
        check("rdData",  id, rdData,       {v.ed1, v.ed0});
    endtask

    logic [31:0] exp_val [1:9];

    initial begin
        rst = 1'b1; rdEnable = '0; rdIndex = '0;
        renameEnable = 1'b0; renameIndex = '0; renameTag = '0;
        commitEnable = 1'b0; commitIndex = '0; commitTag = '0; commitData = '0; flush = 1'b0;

        //         rst re    ri0 ri1 rn rni rnt cm ci ct cd            fl ev    eb    et0 et1 ed0           ed1
        tbl[0]  = mk(1, 2'b11, 5, 5, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0);
        tbl[1]  = mk(0, 2'b11, 5, 5, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2'b11, 2'b00, 0, 0, 32'h0,        32'h0);
        tbl[2]  = mk(0, 2'b00, 0, 0, 1, 3, 7, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0);
        tbl[3]  = mk(0, 2'b11, 3, 3, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2'b11, 2'b11, 7, 7, 32'h0,        32'h0);
        tbl[4]  = mk(0, 2'b11, 3, 0, 0, 0, 0, 1, 3, 7, 32'hDEADBEEF, 0, 2'b11, 2'b00, 0, 0, 32'hDEADBEEF, 32'h0);
        tbl[5]  = mk(0, 2'b11, 3, 3, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2'b11, 2'b00, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[6]  = mk(0, 2'b00, 0, 0, 1, 4, 2, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0);
        tbl[7]  = mk(0, 2'b00, 0, 0, 1, 4, 9, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0);
        tbl[8]  = mk(0, 2'b01, 4, 4, 0, 0, 0, 1, 4, 2, 32'h11,       0, 2'b01, 2'b01, 9, 0, 32'h0,        32'h0);
        tbl[9]  = mk(0, 2'b10, 0, 4, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2'b10, 2'b10, 0, 9, 32'h0,        32'h0);
        tbl[10] = mk(0, 2'b10, 0, 4, 0, 0, 0, 1, 4, 9, 32'h22,       0, 2'b10, 2'b00, 0, 0, 32'h0,        32'h22);
        tbl[11] = mk(0, 2'b01, 4, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2'b01, 2'b00, 0, 0, 32'h22,       32'h0);
        tbl[12] = mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 6, 0, 32'h55,       0, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0);
        tbl[13] = mk(0, 2'b01, 6, 0, 1, 6, 1, 0, 0, 0, 32'h0,        0, 2'b01, 2'b00, 0, 0, 32'h55,       32'h0);
        tbl[14] = mk(0, 2'b11, 6, 6, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2'b11, 2'b11, 1, 1, 32'h0,        32'h0);
        tbl[15] = mk(0, 2'b11, 0, 0, 1, 0, 3, 1, 0, 3, 32'hFFFFFFFF, 0, 2'b11, 2'b00, 0, 0, 32'h0,        32'h0);
        tbl[16] = mk(0, 2'b11, 0, 6, 0, 0, 0, 0, 0, 0, 32'h0,        0, 2'b11, 2'b10, 0, 1, 32'h0,        32'h0);

        for (int i = 0; i < 17; i++) apply(tbl[i], i);

        // Flush scenario: seed x9, rename x1..x8, then flush with competing rename and commit.
        apply(mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 9, 0, 32'h99, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0), 100);
        for (int i = 1; i <= 8; i++)
            apply(mk(0, 2'b00, 0, 0, 1, 5'(i), 5'(i), 0, 0, 0, 32'h0, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0), 100 + i);
        apply(mk(0, 2'b11, 7, 2, 0, 0, 0, 0, 0, 0, 32'h0, 0, 2'b11, 2'b11, 7, 2, 32'h0, 32'h0), 110);
        apply(mk(0, 2'b11, 2, 9, 1, 9, 10, 1, 2, 2, 32'h77, 1, 2'b11, 2'b00, 0, 0, 32'h77, 32'h99), 111);

        exp_val[1] = 32'h0;  exp_val[2] = 32'h77; exp_val[3] = 32'hDEADBEEF;
        exp_val[4] = 32'h22; exp_val[5] = 32'h0;  exp_val[6] = 32'h55;
        exp_val[7] = 32'h0;  exp_val[8] = 32'h0;  exp_val[9] = 32'h99;
        for (int i = 1; i <= 9; i++)
            apply(mk(0, 2'b11, 5'(i), 5'(i), 0, 0, 0, 0, 0, 0, 32'h0, 0, 2'b11, 2'b00, 0, 0,
                     exp_val[i], exp_val[i]), 120 + i);

        // Reset with pending renames wipes state and the response registers.
        apply(mk(0, 2'b00, 0, 0, 1, 10, 4, 0, 0, 0, 32'h0, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0), 140);
        apply(mk(0, 2'b11, 10, 3, 1, 11, 5, 0, 0, 0, 32'h0, 0, 2'b11, 2'b01, 4, 0, 32'h0, 32'hDEADBEEF), 141);
        apply(mk(1, 2'b11, 10, 11, 1, 12, 6, 1, 3, 0, 32'h5A, 0, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0), 142);
        apply(mk(0, 2'b11, 10, 11, 0, 0, 0, 0, 0, 0, 32'h0, 0, 2'b11, 2'b00, 0, 0, 32'h0, 32'h0), 143);
        apply(mk(0, 2'b11, 3, 12, 0, 0, 0, 0, 0, 0, 32'h0, 0, 2'b11, 2'b00, 0, 0, 32'h0, 32'h0), 144);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
